// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time requests to a
// variable-latency instruction memory and presents each returned word with its
// PC+2 in the IF/ID register, honouring stall, branch redirect and HLT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus2,
    output logic        if_valid,
    output logic        halted
);

    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic              req_q;
    logic [XLEN-1:0]   addr_q;
    logic              drop_q;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   pc2_q;
    logic              ifv_q;
    logic              halted_q;
    logic [XLEN-1:0]   hold_instr_q;
    logic [XLEN-1:0]   hold_pc2_q;

    logic [XLEN-1:0]   pc_inc;
    logic              ifid_free;
    logic              rdata_hlt;
    logic              hold_hlt;
    logic              req_in_flight;

    // Decode helpers shared by the state machine
    assign pc_inc        = pc_q + XLEN'(2);
    assign ifid_free     = !stall || !ifv_q;
    assign rdata_hlt     = (imem_rdata[15:12] == HLT_OPCODE);
    assign hold_hlt      = (hold_instr_q[15:12] == HLT_OPCODE);
    // A request is on the bus this cycle or still awaiting its response
    assign req_in_flight = (state_q == S_FETCH && req_q) || (state_q == S_WAIT && !imem_valid);

    // Fetch FSM, PC, memory request and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            instr_q      <= '0;
            pc2_q        <= '0;
            ifv_q        <= 1'b0;
            halted_q     <= 1'b0;
            hold_instr_q <= '0;
            hold_pc2_q   <= '0;
            // A request cut off by reset may still answer; swallow that answer
            drop_q       <= (state_q == S_WAIT) && !imem_valid;
        end else begin
            if (!stall) begin
                ifv_q <= 1'b0;
            end
            if (imem_valid) begin
                drop_q <= 1'b0;
            end

            if (redirect_en) begin
                pc_q     <= redirect_pc;
                ifv_q    <= 1'b0;
                halted_q <= 1'b0;
                if (req_in_flight) begin
                    state_q <= S_WAIT;
                    req_q   <= 1'b0;
                    drop_q  <= 1'b1;
                end else begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= redirect_pc;
                end
            end else begin
                case (state_q)
                    // req_q low only on the first cycle out of reset: arm the strobe
                    S_FETCH: begin
                        req_q  <= !req_q;
                        addr_q <= pc_q;
                        if (req_q) begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_valid) begin
                            if (drop_q) begin
                                state_q <= S_FETCH;
                                req_q   <= 1'b1;
                                addr_q  <= pc_q;
                            end else begin
                                pc_q <= pc_inc;
                                if (ifid_free) begin
                                    instr_q <= imem_rdata;
                                    pc2_q   <= pc_inc;
                                    ifv_q   <= 1'b1;
                                    if (rdata_hlt) begin
                                        state_q  <= S_HALTED;
                                        halted_q <= 1'b1;
                                    end else begin
                                        state_q <= S_FETCH;
                                        req_q   <= 1'b1;
                                        addr_q  <= pc_inc;
                                    end
                                end else begin
                                    hold_instr_q <= imem_rdata;
                                    hold_pc2_q   <= pc_inc;
                                    state_q      <= S_HOLD;
                                end
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            instr_q <= hold_instr_q;
                            pc2_q   <= hold_pc2_q;
                            ifv_q   <= 1'b1;
                            if (hold_hlt) begin
                                state_q  <= S_HALTED;
                                halted_q <= 1'b1;
                            end else begin
                                state_q <= S_FETCH;
                                req_q   <= 1'b1;
                                addr_q  <= pc_q;
                            end
                        end
                    end
                    S_HALTED: begin
                        halted_q <= 1'b1;
                    end
                    default: begin
                        state_q <= S_FETCH;
                    end
                endcase
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instruction = instr_q;
    assign pc_plus2    = pc2_q;
    assign if_valid    = ifv_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural instruction memory with programmable
// latency plus a scoreboard of the instruction stream decode should consume.
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        stall;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic [15:0] instruction;
    logic [15:0] pc_plus2;
    logic        if_valid;
    logic        halted;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    int          lat;
    logic        hlt_en;
    logic [15:0] hlt_addr;
    logic        mem_pend = 1'b0;
    int          mem_rem  = 0;
    logic [15:0] mem_a    = 16'h0000;

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instruction (instruction),
        .pc_plus2    (pc_plus2),
        .if_valid    (if_valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] w;
        w = 16'h1000 + a;
        if (hlt_en && a == hlt_addr) w = 16'hF000;
        return w;
    endfunction

    // Memory: a request seen in cycle c is answered in cycle c+lat
    always @(negedge clk) begin
        imem_valid = 1'b0;
        if (mem_pend) begin
            mem_rem = mem_rem - 1;
            if (mem_rem == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(mem_a);
                mem_pend   = 1'b0;
            end
        end
        if (imem_req) begin
            mem_pend = 1'b1;
            mem_rem  = lat;
            mem_a    = imem_addr;
        end
    end

    task automatic do_reset(input int l);
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 16'h0000;
        rst         = 1'b1;
        lat         = l;
        exp_q.delete();
        repeat (6) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); else n_pass++;
        n_checks++; if (instruction !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", instruction); else n_pass++;
        n_checks++; if (pc_plus2 !== 16'h0000) $display("FAIL reset_pc2: got %h want 0000", pc_plus2); else n_pass++;
        n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_ifv: got %b want 0", if_valid); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    endtask

    task automatic test_straight();
        exp_t e;
        int   last_v;
        do_reset(1);
        last_v = -1;
        exp_q.push_back('{16'h1000, 16'h0002});
        exp_q.push_back('{16'h1002, 16'h0004});
        exp_q.push_back('{16'h1004, 16'h0006});
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (t == 1) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
                    $display("FAIL straight_first_req: got req %b addr %h want 1 %h", imem_req, imem_addr, RESET_PC);
                else n_pass++;
            end
            if (if_valid) begin
                if (last_v >= 0) begin
                    n_checks++;
                    if (t - last_v != 2) $display("FAIL straight_spacing: got %0d cycles want 2", t - last_v);
                    else n_pass++;
                end
                last_v = t;
            end
            if (if_valid && !stall) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL straight_extra: got %h/%h, none expected", instruction, pc_plus2);
                else begin
                    e = exp_q.pop_front();
                    if (instruction !== e.instr || pc_plus2 !== e.pc2)
                        $display("FAIL straight_stream: got %h/%h want %h/%h", instruction, pc_plus2, e.instr, e.pc2);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL straight_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_stall();
        exp_t e;
        logic held_bad;
        do_reset(1);
        held_bad = 1'b0;
        exp_q.push_back('{16'h1000, 16'h0002});
        exp_q.push_back('{16'h1002, 16'h0004});
        exp_q.push_back('{16'h1004, 16'h0006});
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            stall = (t >= 3 && t <= 6);
            if (t >= 4 && t <= 6 && (if_valid !== 1'b1 || instruction !== 16'h1000)) held_bad = 1'b1;
            if (t == 8) begin
                n_checks++;
                if (if_valid !== 1'b1 || instruction !== 16'h1002)
                    $display("FAIL stall_release: got %b/%h want 1/1002", if_valid, instruction);
                else n_pass++;
            end
            if (if_valid && !stall) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL stall_extra: got %h/%h, none expected", instruction, pc_plus2);
                else begin
                    e = exp_q.pop_front();
                    if (instruction !== e.instr || pc_plus2 !== e.pc2)
                        $display("FAIL stall_stream: got %h/%h want %h/%h", instruction, pc_plus2, e.instr, e.pc2);
                    else n_pass++;
                end
            end
        end
        stall = 1'b0;
        n_checks++; if (held_bad) $display("FAIL stall_hold: got IF/ID changed want 1/1000 held"); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL stall_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_redirect();
        exp_t e;
        do_reset(3);
        exp_q.push_back('{16'h1000, 16'h0002});
        exp_q.push_back('{16'h1002, 16'h0004});
        exp_q.push_back('{16'h1040, 16'h0042});
        for (int t = 1; t <= 22; t++) begin
            @(negedge clk);
            stall       = (t == 13 || t == 14);
            redirect_en = (t == 14);
            redirect_pc = 16'h0040;
            if (t == 15) begin
                n_checks++;
                if (if_valid !== 1'b0) $display("FAIL redirect_flush: got if_valid %b want 0", if_valid); else n_pass++;
            end
            if (t == 16) begin
                n_checks++;
                if (imem_req !== 1'b0) $display("FAIL redirect_early_req: got %b want 0", imem_req); else n_pass++;
            end
            if (t == 17) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0040)
                    $display("FAIL redirect_target: got req %b addr %h want 1 0040", imem_req, imem_addr);
                else n_pass++;
            end
            if (if_valid && !stall) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL redirect_extra: got %h/%h, none expected", instruction, pc_plus2);
                else begin
                    e = exp_q.pop_front();
                    if (instruction !== e.instr || pc_plus2 !== e.pc2)
                        $display("FAIL redirect_stream: got %h/%h want %h/%h", instruction, pc_plus2, e.instr, e.pc2);
                    else n_pass++;
                end
            end
        end
        redirect_en = 1'b0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL redirect_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_halt();
        exp_t e;
        logic req_seen;
        logic halt_lost;
        hlt_en   = 1'b1;
        hlt_addr = 16'h0008;
        do_reset(1);
        req_seen  = 1'b0;
        halt_lost = 1'b0;
        exp_q.push_back('{16'h1000, 16'h0002});
        exp_q.push_back('{16'h1002, 16'h0004});
        exp_q.push_back('{16'h1004, 16'h0006});
        exp_q.push_back('{16'h1006, 16'h0008});
        exp_q.push_back('{16'hF000, 16'h000A});
        exp_q.push_back('{16'h1010, 16'h0012});
        for (int t = 1; t <= 36; t++) begin
            @(negedge clk);
            redirect_en = (t == 32);
            redirect_pc = 16'h0010;
            if (t == 10) begin
                n_checks++;
                if (halted !== 1'b0) $display("FAIL halt_early: got %b want 0", halted); else n_pass++;
            end
            if (t == 11) begin
                n_checks++;
                if (halted !== 1'b1 || if_valid !== 1'b1 || pc_plus2 !== 16'h000A)
                    $display("FAIL halt_rise: got halted %b ifv %b pc2 %h want 1 1 000a", halted, if_valid, pc_plus2);
                else n_pass++;
            end
            if (t >= 12 && t <= 31) begin
                if (imem_req !== 1'b0) req_seen = 1'b1;
                if (halted !== 1'b1) halt_lost = 1'b1;
            end
            if (t == 33) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || halted !== 1'b0)
                    $display("FAIL halt_resume: got req %b addr %h halted %b want 1 0010 0", imem_req, imem_addr, halted);
                else n_pass++;
            end
            if (if_valid && !stall) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL halt_extra: got %h/%h, none expected", instruction, pc_plus2);
                else begin
                    e = exp_q.pop_front();
                    if (instruction !== e.instr || pc_plus2 !== e.pc2)
                        $display("FAIL halt_stream: got %h/%h want %h/%h", instruction, pc_plus2, e.instr, e.pc2);
                    else n_pass++;
                end
            end
        end
        redirect_en = 1'b0;
        hlt_en      = 1'b0;
        n_checks++; if (req_seen) $display("FAIL halt_quiet: got imem_req while halted want none"); else n_pass++;
        n_checks++; if (halt_lost) $display("FAIL halt_sticky: got halted dropped want 1"); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL halt_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        exp_t e;
        do_reset(1);
        exp_q.push_back('{16'h0FFE, 16'h0000});
        exp_q.push_back('{16'h1000, 16'h0002});
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            redirect_en = (t == 1);
            redirect_pc = 16'hFFFE;
            if (t == 2) begin
                n_checks++;
                if (imem_req !== 1'b0) $display("FAIL wrap_drop_req: got %b want 0", imem_req); else n_pass++;
            end
            if (t == 3) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE)
                    $display("FAIL wrap_target: got req %b addr %h want 1 fffe", imem_req, imem_addr);
                else n_pass++;
            end
            if (t == 5) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
                    $display("FAIL wrap_next_addr: got req %b addr %h want 1 0000", imem_req, imem_addr);
                else n_pass++;
            end
            if (if_valid && !stall) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL wrap_extra: got %h/%h, none expected", instruction, pc_plus2);
                else begin
                    e = exp_q.pop_front();
                    if (instruction !== e.instr || pc_plus2 !== e.pc2)
                        $display("FAIL wrap_stream: got %h/%h want %h/%h", instruction, pc_plus2, e.instr, e.pc2);
                    else n_pass++;
                end
            end
        end
        redirect_en = 1'b0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL wrap_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_request();
        exp_t e;
        do_reset(2);
        exp_q.push_back('{16'h1000, 16'h0002});
        exp_q.push_back('{16'h1000, 16'h0002});
        for (int t = 1; t <= 11; t++) begin
            @(negedge clk);
            rst = (t == 5);
            if (t == 6) begin
                n_checks++;
                if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instruction !== 16'h0000 ||
                    pc_plus2 !== 16'h0000 || if_valid !== 1'b0 || halted !== 1'b0)
                    $display("FAIL midreset_values: got req %b addr %h instr %h pc2 %h ifv %b halted %b want all reset",
                             imem_req, imem_addr, instruction, pc_plus2, if_valid, halted);
                else n_pass++;
            end
            if (t == 7) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
                    $display("FAIL midreset_refetch: got req %b addr %h want 1 %h", imem_req, imem_addr, RESET_PC);
                else n_pass++;
            end
            if (if_valid && !stall) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL midreset_extra: got %h/%h, none expected", instruction, pc_plus2);
                else begin
                    e = exp_q.pop_front();
                    if (instruction !== e.instr || pc_plus2 !== e.pc2)
                        $display("FAIL midreset_stream: got %h/%h want %h/%h", instruction, pc_plus2, e.instr, e.pc2);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL midreset_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 16'h0000;
        lat         = 1;
        hlt_en      = 1'b0;
        hlt_addr    = 16'h0000;

        test_reset();
        test_straight();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid_request();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
